bus_arbiter_n: RTL and testbench
================================

Name: bus_arbiter_n

Overview:
Parametrised N-master system-bus arbiter, next generation of the two-master fixed-priority arbiter. Sits between the masters and the address decoder/slave mux. Grants one master per tenure and latches that master's slave select. Holds the grant until trans_done and supports fixed-priority or round-robin selection.

Parameters:
N_MASTERS, 2, number of masters (2..8); master 0 is the highest priority in fixed mode.
SLV_W, 2, slave-select width per master.
ROUND_ROBIN, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
TIMEOUT_CYCLES, 255, watchdog limit in clocks (used only with ARBITER_TIMEOUT_EN).
GNT_W, $clog2(N_MASTERS+1), derived width of bus_grant; not to be overridden.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
m_request  in  N_MASTERS  per-master bus request
m_slave_sel  in  N_MASTERS*SLV_W  flattened slave selects; master i uses bits [i*SLV_W +: SLV_W]
trans_done  in  1  one-cycle pulse from the slave side ending the current tenure
m_grant  out  N_MASTERS  one-hot grant, registered
bus_grant  out  GNT_W  granted master number, i+1; 0 = none
slave_sel  out  SLV_W  slave select latched from the granted master
bus_busy  out  1  high while a master owns the bus
arbiter_busy  out  1  high in any non-IDLE state
timeout  out  1  one-cycle pulse on a watchdog abort; tied 0 without the macro

Behaviour:
- Reset (rst=0, async): state=IDLE; m_grant=0, bus_grant=0, slave_sel=0, bus_busy=0, arbiter_busy=0, timeout=0; RR pointer=N_MASTERS-1, so master 0 is searched first.
- All outputs are registered. No combinational path exists from inputs to outputs.
- States: IDLE, GRANT (plus ABORT when the macro is enabled).
- IDLE:
  - If m_request==0, stay in IDLE with all outputs 0.
  - Otherwise, at the next edge go to GRANT with the winner w: m_grant=1<<w, bus_grant=w+1, slave_sel=m_slave_sel[w], bus_busy=1, arbiter_busy=1.
  - Latency: one clock from request sampled to grant visible.
- Winner selection:
  - Fixed mode: lowest-index requesting master.
  - RR mode: first requester at index ptr+1, ptr+2, ... wrapping modulo N_MASTERS.
  - ptr is updated to w when the grant is issued.
- GRANT:
  - Grant and slave_sel are frozen for the whole tenure. Changes on m_slave_sel[w] are ignored.
  - Requests from other masters are ignored; there is no pre-emption, including by master 0 in fixed mode.
- GRANT -> IDLE at the next edge when trans_done==1 or m_request[w]==0 (the owner withdrew). All outputs return to 0 on that edge.
- Turnaround: at least one dead cycle with m_grant=0 between consecutive tenures. A back-to-back request is granted on the second edge after trans_done.
- trans_done is ignored while in IDLE.
- trans_done arriving on the same edge as a new request in IDLE is ignored; the grant is still issued.
- N_MASTERS=1 degenerates to a request/grant handshake for a single master; ptr stays at 0.
- Reset asserted mid-tenure clears everything immediately. The tenure is lost with no completion signalled.

Optional Feature:
ARBITER_TIMEOUT_EN
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to GRANT and increments each GRANT cycle without trans_done.
  - On reaching TIMEOUT_CYCLES: go to ABORT. In ABORT, m_grant=0, bus_grant=0, bus_busy=0, arbiter_busy=1, timeout=1 for exactly one cycle, then IDLE.
  - In RR mode ptr keeps the aborted master, so it gets lowest priority next.
  - trans_done on the same edge the count reaches TIMEOUT_CYCLES wins: normal release, no timeout.
- Undefined: no counter, no ABORT state, timeout tied 0, and a tenure may last indefinitely.

Decomposition:
- Package bus_arb_pkg: state enum (IDLE, GRANT, ABORT), constant NO_GRANT=0, function for the flattened-slice index.
- Sub-module arb_rr_picker: combinational one-hot picker taking requests, ptr and mode, returning a one-hot winner and its index; instantiated once.
- State register, latches and watchdog stay in bus_arbiter_n.

Test Plan:
- Fixed mode, N=4, m_request=4'b1010 in IDLE -> next edge m_grant=4'b0010, bus_grant=2, slave_sel=m_slave_sel[1]; held until trans_done; dead cycle; then m_grant=4'b1000, bus_grant=4.
- RR mode, N=4, all four requesting continuously, trans_done every 3rd GRANT cycle -> grant order 0,1,2,3,0 with exactly one m_grant=0 cycle between tenures.
- During master 2's tenure, master 0 asserts and m_slave_sel[2] changes from 1 to 3 -> m_grant and slave_sel=1 unchanged until trans_done; master 0 is then granted 2 edges later.
- Owner drops m_request without trans_done -> outputs 0 at the next edge, state IDLE; trans_done pulsed in IDLE -> no effect.
- rst driven low mid-tenure between clock edges -> all outputs 0 immediately; after release with m_request=4'b0001 -> grant to master 0.
- ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=8, no trans_done -> timeout pulses 1 cycle after 8 GRANT cycles, arbiter_busy=1 and bus_busy=0 in that cycle, then IDLE; trans_done on cycle 8 -> no timeout.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the N-master bus arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StAbort
    } arb_state_e;

    localparam int unsigned NO_GRANT = 0;

    // LSB of master idx's field inside a flattened per-master bus.
    function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/arb_rr_picker.sv
// Combinational winner picker: lowest-index first, or round-robin starting after ptr_i.
module arb_rr_picker #(
    parameter int unsigned N    = 2,
    parameter int unsigned IdxW = 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    input  logic            rr_mode_i,
    output logic [N-1:0]    win_oh_o,
    output logic [IdxW-1:0] win_idx_o,
    output logic            valid_o
);

    int unsigned     cand;
    logic [IdxW-1:0] cand_idx;

    always_comb begin
        win_oh_o  = '0;
        win_idx_o = '0;
        valid_o   = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand     = rr_mode_i ? (32'(ptr_i) + k + 1) % N : k;
            cand_idx = IdxW'(cand);
            if (!valid_o && req_i[cand_idx]) begin
                valid_o            = 1'b1;
                win_oh_o[cand_idx] = 1'b1;
                win_idx_o          = cand_idx;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_n.sv
// N-master bus arbiter: one tenure per grant, held until trans_done or owner withdrawal.
// Define ARBITER_TIMEOUT_EN to add a watchdog that aborts tenures after TIMEOUT_CYCLES.
module bus_arbiter_n
    import bus_arb_pkg::*;
#(
    parameter int unsigned N_MASTERS      = 2,
    parameter int unsigned SLV_W          = 2,
    parameter int unsigned ROUND_ROBIN    = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned GNT_W          = $clog2(N_MASTERS + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_MASTERS-1:0]       m_request,
    input  logic [N_MASTERS*SLV_W-1:0] m_slave_sel,
    input  logic                       trans_done,
    output logic [N_MASTERS-1:0]       m_grant,
    output logic [GNT_W-1:0]           bus_grant,
    output logic [SLV_W-1:0]           slave_sel,
    output logic                       bus_busy,
    output logic                       arbiter_busy,
    output logic                       timeout
);

    localparam int unsigned IdxW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    arb_state_e           state_q, state_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic [IdxW-1:0]      owner_q, owner_d;
    logic [IdxW-1:0]      ptr_q, ptr_d;
    logic [SLV_W-1:0]     slave_sel_q, slave_sel_d;

    logic [N_MASTERS-1:0] pick_oh;
    logic [IdxW-1:0]      pick_idx;
    logic                 pick_valid;
    logic                 owner_release;

    logic [SLV_W-1:0] sel_arr [N_MASTERS];

    for (genvar g = 0; g < N_MASTERS; g++) begin : gen_sel_slice
        assign sel_arr[g] = m_slave_sel[slice_lsb(g, SLV_W) +: SLV_W];
    end

    arb_rr_picker #(
        .N    (N_MASTERS),
        .IdxW (IdxW)
    ) u_picker (
        .req_i     (m_request),
        .ptr_i     (ptr_q),
        .rr_mode_i (ROUND_ROBIN != 0),
        .win_oh_o  (pick_oh),
        .win_idx_o (pick_idx),
        .valid_o   (pick_valid)
    );

    // Tenure ends on trans_done or when the owner drops its own request.
    assign owner_release = trans_done || ((m_request & grant_q) == '0);

`ifdef ARBITER_TIMEOUT_EN
    localparam int unsigned CntW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_q     <= '0;
            owner_q     <= '0;
            ptr_q       <= IdxW'(N_MASTERS - 1);
            slave_sel_q <= '0;
        end else begin
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            slave_sel_q <= slave_sel_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        slave_sel_d = slave_sel_q;
`ifdef ARBITER_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d     = StGrant;
                    grant_d     = pick_oh;
                    owner_d     = pick_idx;
                    ptr_d       = pick_idx;
                    slave_sel_d = sel_arr[pick_idx];
`ifdef ARBITER_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            StGrant: begin
                if (owner_release) begin
                    state_d = StIdle;
                    grant_d = '0;
                end
`ifdef ARBITER_TIMEOUT_EN
                else if (cnt_q == LastCnt) begin
                    state_d = StAbort;
                    grant_d = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
`endif
            end
            StAbort: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        m_grant      = '0;
        bus_grant    = GNT_W'(NO_GRANT);
        slave_sel    = '0;
        bus_busy     = 1'b0;
        arbiter_busy = (state_q != StIdle);
        timeout      = 1'b0;
        if (state_q == StGrant) begin
            m_grant   = grant_q;
            bus_grant = GNT_W'(owner_q) + GNT_W'(1);
            slave_sel = slave_sel_q;
            bus_busy  = 1'b1;
        end
`ifdef ARBITER_TIMEOUT_EN
        timeout = (state_q == StAbort);
`endif
    end

endmodule

// File: tb/tb_bus_arbiter_n.sv
// Bench for bus_arbiter_n: a fixed-priority and a round-robin instance (N=4) checked every
// cycle against a tenure-level model, plus directed literal expectations.
module tb_bus_arbiter_n;

`ifdef ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_f, req_r;
    logic [7:0] sel_f, sel_r;
    logic       done_f, done_r;

    logic [3:0] f_grant, r_grant;
    logic [2:0] f_bg, r_bg;
    logic [1:0] f_ss, r_ss;
    logic       f_bb, r_bb, f_ab, r_ab, f_to, r_to;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bus_arbiter_n #(
        .N_MASTERS(4), .SLV_W(2), .ROUND_ROBIN(0), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut_f (
        .clk(clk), .rst(rst), .m_request(req_f), .m_slave_sel(sel_f), .trans_done(done_f),
        .m_grant(f_grant), .bus_grant(f_bg), .slave_sel(f_ss), .bus_busy(f_bb),
        .arbiter_busy(f_ab), .timeout(f_to)
    );

    bus_arbiter_n #(
        .N_MASTERS(4), .SLV_W(2), .ROUND_ROBIN(1), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut_r (
        .clk(clk), .rst(rst), .m_request(req_r), .m_slave_sel(sel_r), .trans_done(done_r),
        .m_grant(r_grant), .bus_grant(r_bg), .slave_sel(r_ss), .bus_busy(r_bb),
        .arbiter_busy(r_ab), .timeout(r_to)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: owner = -1 when the bus is free; held counts completed grant cycles.
    int         m_owner [2];
    int         m_ptr   [2];
    int         m_held  [2];
    bit         m_abort [2];
    logic [1:0] m_sel   [2];

    function automatic int pick(input logic [3:0] req, input bit rr, input int ptr);
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = rr ? (ptr + k) % 4 : k - 1;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_step(input int i, input logic [3:0] req, input logic [7:0] sel,
                              input logic done);
        int w;
        if (m_abort[i]) begin
            m_abort[i] = 1'b0;
        end else if (m_owner[i] < 0) begin
            w = pick(req, i == 1, m_ptr[i]);
            if (w >= 0) begin
                m_owner[i] = w;
                m_ptr[i]   = w;
                m_sel[i]   = sel[w*2 +: 2];
                m_held[i]  = 0;
            end
        end else if (done || !req[m_owner[i]]) begin
            m_owner[i] = -1;
        end else begin
            m_held[i]++;
            if (TO_EN && m_held[i] == TIMEOUT) begin
                m_owner[i] = -1;
                m_abort[i] = 1'b1;
            end
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                m_owner[i] = -1;
                m_ptr[i]   = 3;
                m_held[i]  = 0;
                m_abort[i] = 1'b0;
                m_sel[i]   = '0;
            end
        end else begin
            model_step(0, req_f, sel_f, done_f);
            model_step(1, req_r, sel_r, done_r);
        end
    end

    task automatic check_dut(input string tag, input int i, input logic [3:0] g,
                             input logic [2:0] bg, input logic [1:0] ss, input logic bb,
                             input logic ab, input logic to);
        bit own;
        own = (m_owner[i] >= 0);
        chk({tag, ".m_grant"}, 32'(g), own ? (32'd1 << m_owner[i]) : 32'd0);
        chk({tag, ".bus_grant"}, 32'(bg), 32'(m_owner[i] + 1));
        chk({tag, ".slave_sel"}, 32'(ss), own ? 32'(m_sel[i]) : 32'd0);
        chk({tag, ".bus_busy"}, 32'(bb), 32'(own));
        chk({tag, ".arbiter_busy"}, 32'(ab), 32'(own || m_abort[i]));
        chk({tag, ".timeout"}, 32'(to), 32'(m_abort[i]));
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            check_dut("fixed", 0, f_grant, f_bg, f_ss, f_bb, f_ab, f_to);
            check_dut("rr", 1, r_grant, r_bg, r_ss, r_bb, r_ab, r_to);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        req_f = '0; req_r = '0; sel_f = '0; sel_r = '0; done_f = 1'b0; done_r = 1'b0;
        repeat (2) step();
        #2 rst = 1'b1;
        step();
        chk("reset_grant", 32'(f_grant), 32'd0);
        chk("reset_arb_busy", 32'(r_ab), 32'd0);

        // Fixed priority: masters 1 and 3 request, 1 wins, then 3 after a dead cycle.
        sel_f = 8'b11_00_10_00;
        req_f = 4'b1010;
        step();
        chk("fix_grant_m1", 32'(f_grant), 32'b0010);
        chk("fix_bus_grant_m1", 32'(f_bg), 32'd2);
        chk("fix_sel_m1", 32'(f_ss), 32'd2);
        repeat (2) step();
        chk("fix_hold_m1", 32'(f_grant), 32'b0010);
        done_f = 1'b1;
        req_f  = 4'b1000;
        step();
        chk("fix_dead_cycle", 32'(f_grant), 32'd0);
        done_f = 1'b0;
        step();
        chk("fix_grant_m3", 32'(f_grant), 32'b1000);
        chk("fix_bus_grant_m3", 32'(f_bg), 32'd4);
        chk("fix_sel_m3", 32'(f_ss), 32'd3);
        req_f = '0;
        step();

        // No pre-emption and frozen slave_sel during master 2's tenure.
        sel_f = 8'b00_01_00_00;
        req_f = 4'b0100;
        step();
        chk("nopre_grant_m2", 32'(f_grant), 32'b0100);
        req_f = 4'b0101;
        sel_f = 8'b00_11_00_00;
        repeat (2) step();
        chk("nopre_hold_grant", 32'(f_grant), 32'b0100);
        chk("nopre_hold_sel", 32'(f_ss), 32'd1);
        done_f = 1'b1;
        step();
        chk("nopre_dead", 32'(f_grant), 32'd0);
        done_f = 1'b0;
        step();
        chk("nopre_grant_m0", 32'(f_grant), 32'b0001);
        chk("nopre_bus_grant_m0", 32'(f_bg), 32'd1);
        req_f = '0;
        step();

        // Owner withdrawal, trans_done in IDLE, trans_done coinciding with a new request.
        req_f = 4'b0010;
        step();
        chk("wd_grant", 32'(f_grant), 32'b0010);
        req_f = '0;
        step();
        chk("wd_release", 32'(f_grant), 32'd0);
        chk("wd_idle", 32'(f_ab), 32'd0);
        done_f = 1'b1;
        step();
        chk("done_in_idle", 32'(f_bb), 32'd0);
        req_f = 4'b0001;
        step();
        chk("done_with_req", 32'(f_grant), 32'b0001);
        done_f = 1'b0;
        req_f  = '0;
        step();

        // Asynchronous reset mid-tenure.
        req_f = 4'b0010;
        step();
        chk("rst_pre_grant", 32'(f_grant), 32'b0010);
        #2 rst = 1'b0;
        #1;
        chk("rst_async_grant", 32'(f_grant), 32'd0);
        chk("rst_async_bg", 32'(f_bg), 32'd0);
        chk("rst_async_bb", 32'(f_bb), 32'd0);
        chk("rst_async_ab", 32'(f_ab), 32'd0);
        req_f = 4'b0001;
        step();
        #2 rst = 1'b1;
        step();
        chk("rst_after_grant", 32'(f_grant), 32'b0001);
        req_f = '0;
        step();

        // Round robin: all request, trans_done on every third grant cycle.
        sel_r = 8'b11_10_01_00;
        req_r = 4'b1111;
        for (int c = 1; c <= 17; c++) begin
            step();
            if (c % 4 == 1) begin
                chk($sformatf("rr_grant_%0d", c), 32'(r_grant), 32'd1 << ((c / 4) % 4));
                chk($sformatf("rr_sel_%0d", c), 32'(r_ss), 32'((c / 4) % 4));
            end
            if (c % 4 == 0) chk($sformatf("rr_dead_%0d", c), 32'(r_grant), 32'd0);
            done_r = (c % 4 == 3);
        end
        done_r = 1'b0;
        req_r  = '0;
        repeat (2) step();

`ifdef ARBITER_TIMEOUT_EN
        req_f = 4'b0001;
        repeat (8) step();
        chk("to_last_grant", 32'(f_grant), 32'b0001);
        chk("to_not_yet", 32'(f_to), 32'd0);
        step();
        chk("to_pulse", 32'(f_to), 32'd1);
        chk("to_arb_busy", 32'(f_ab), 32'd1);
        chk("to_bus_busy", 32'(f_bb), 32'd0);
        chk("to_grant_off", 32'(f_grant), 32'd0);
        req_f = '0;
        step();
        chk("to_pulse_end", 32'(f_to), 32'd0);
        chk("to_idle", 32'(f_ab), 32'd0);
        req_f = 4'b0001;
        repeat (8) step();
        done_f = 1'b1;
        step();
        chk("to_done_wins_to", 32'(f_to), 32'd0);
        chk("to_done_wins_ab", 32'(f_ab), 32'd0);
        done_f = 1'b0;
        req_f  = '0;
        step();
        chk("to_done_wins_after", 32'(f_to), 32'd0);
`else
        req_f = 4'b0001;
        repeat (20) step();
        chk("long_tenure_grant", 32'(f_grant), 32'b0001);
        chk("long_tenure_to", 32'(f_to), 32'd0);
        req_f = '0;
        step();
`endif

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
